// File: rtl/dff_reg.sv
// n-bit edge-triggered storage register with clock enable, asynchronous
// active-high clear, and true/complement outputs.
module dff_reg #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [n-1:0] d,
   output logic [n-1:0] q,
   output logic [n-1:0] qn
);

   if (n < 1) begin : g_bad_width
      $error("dff_reg: parameter n must be at least 1 (got %0d)", n);
   end

   logic [n-1:0] q_reg;

   // Clear wins over everything; otherwise en gates the rising-edge capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg <= '0;
      end else if (en) begin
         q_reg <= d;
      end
   end

   // Complement is taken from the one stored copy so qn can never drift from ~q.
   assign q  = q_reg;
   assign qn = ~q_reg;

endmodule

// File: tb/tb_dff_reg.sv
// Self-checking bench for dff_reg at n = 32, 8 and 1 using a per-cycle
// expected-value scoreboard.
module tb_dff_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic [31:0] d32 = '0;
   logic [7:0]  d8  = '0;
   logic        d1  = 1'b0;
   logic [31:0] q32, qn32;
   logic [7:0]  q8, qn8;
   logic        q1, qn1;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   logic [31:0] m32 = '0;
   logic [7:0]  m8  = '0;
   logic        m1  = 1'b0;
   logic [31:0] sb32[$];
   logic [7:0]  sb8[$];
   logic        sb1[$];
   logic [31:0] e32;
   logic [7:0]  e8;
   logic        e1;

   always #5 clk = ~clk;

   dff_reg #(.n(32)) u_dut32 (.clk(clk), .rst(rst), .en(en), .d(d32), .q(q32), .qn(qn32));
   dff_reg #(.n(8))  u_dut8  (.clk(clk), .rst(rst), .en(en), .d(d8),  .q(q8),  .qn(qn8));
   dff_reg #(.n(1))  u_dut1  (.clk(clk), .rst(rst), .en(en), .d(d1),  .q(q1),  .qn(qn1));

   // Drive one cycle of stimulus and push what every register must hold after the edge.
   task automatic drive(input logic e, input logic [31:0] v32, input logic [7:0] v8, input logic v1);
      en  = e;
      d32 = v32;
      d8  = v8;
      d1  = v1;
      if (rst) begin
         m32 = '0; m8 = '0; m1 = 1'b0;
      end else if (e) begin
         m32 = v32; m8 = v8; m1 = v1;
      end
      sb32.push_back(m32);
      sb8.push_back(m8);
      sb1.push_back(m1);
   endtask

   task automatic next_edge();
      @(posedge clk);
      @(negedge clk);
      e32 = sb32.pop_front();
      e8  = sb8.pop_front();
      e1  = sb1.pop_front();
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (qn32 !== ~q32 || qn8 !== ~q8 || qn1 !== ~q1) begin
            errors++;
            $display("FAIL complement q32=%h qn32=%h q8=%h qn8=%h q1=%b qn1=%b (qn must equal ~q)",
                     q32, qn32, q8, qn8, q1, qn1);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      d32 = 32'h1234_5678; d8 = 8'hFF; d1 = 1'b1; en = 1'b1;
      #1;
      checks++;
      if (q32 !== 32'h0 || qn32 !== 32'hFFFF_FFFF || q8 !== 8'h00 || q1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_assert q32=%h qn32=%h q8=%h q1=%b required q32=00000000 qn32=ffffffff q8=00 q1=0",
                  q32, qn32, q8, q1);
      end
      drive(1'b1, 32'h1234_5678, 8'hFF, 1'b1);
      next_edge();
      checks++;
      if (q32 !== e32 || qn32 !== ~e32 || q32 !== 32'h0) begin
         errors++;
         $display("FAIL reset_hold q32=%h qn32=%h required q=%h qn=%h", q32, qn32, e32, ~e32);
      end
      rst = 1'b0;
      en  = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_load();
      drive(1'b1, 32'h00A9_7C01, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         next_edge();
         checks++;
         if (q32 !== e32 || qn32 !== ~e32 || qn32 !== 32'hFF56_83FE) begin
            errors++;
            $display("FAIL load[%0d] q32=%h qn32=%h required q=%h qn=ff5683fe", i, q32, qn32, e32);
         end
         if (i < 2) drive(1'b1, 32'h00A9_7C01, 8'h00, 1'b0);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 32'hDEAD_BEEF, 8'h00, 1'b0);
         if (i == 2) begin
            #2 en = 1'b1;  // toggle between edges; only the edge sample matters
            #2 en = 1'b0;
         end
         next_edge();
         checks++;
         if (q32 !== e32 || qn32 !== ~e32 || q32 !== 32'h00A9_7C01) begin
            errors++;
            $display("FAIL hold[%0d] q32=%h qn32=%h required q=%h", i, q32, qn32, e32);
         end
      end
      drive(1'b1, 32'hDEAD_BEEF, 8'h00, 1'b0);
      next_edge();
      checks++;
      if (q32 !== e32 || q32 !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL reenable q32=%h required q=%h", q32, e32);
      end
   endtask

   task automatic test_async_reset();
      #2 rst = 1'b1;
      m32 = '0; m8 = '0; m1 = 1'b0;
      #1;
      checks++;
      if (q32 !== 32'h0 || qn32 !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL async_reset q32=%h qn32=%h required q=00000000 qn=ffffffff", q32, qn32);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'hCAFE_F00D, 8'h77, 1'b1);
         next_edge();
         checks++;
         if (q32 !== e32 || q8 !== e8 || q1 !== e1) begin
            errors++;
            $display("FAIL reset_en_ignored[%0d] q32=%h q8=%h q1=%b required %h %h %b",
                     i, q32, q8, q1, e32, e8, e1);
         end
      end
      rst = 1'b0;
      drive(1'b1, 32'hCAFE_F00D, 8'h77, 1'b1);
      #1;
      checks++;
      if (q32 !== 32'h0) begin
         errors++;
         $display("FAIL release_no_load q32=%h required 00000000", q32);
      end
      next_edge();
      checks++;
      if (q32 !== e32 || q32 !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL first_capture q32=%h required %h", q32, e32);
      end
   endtask

   task automatic test_width();
      drive(1'b1, 32'h0, 8'hA5, 1'b1);
      next_edge();
      checks++;
      if (q8 !== e8 || qn8 !== 8'h5A || q1 !== e1 || qn1 !== 1'b0) begin
         errors++;
         $display("FAIL width_load q8=%h qn8=%h q1=%b qn1=%b required q8=%h qn8=5a q1=%b qn1=0",
                  q8, qn8, q1, qn1, e8, e1);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h0, 8'h3C, 1'b0);
         next_edge();
         checks++;
         if (q8 !== e8 || q8 !== 8'hA5 || q1 !== e1 || q1 !== 1'b1) begin
            errors++;
            $display("FAIL width_hold[%0d] q8=%h q1=%b required q8=%h q1=%b", i, q8, q1, e8, e1);
         end
      end
      drive(1'b1, 32'h0, 8'h3C, 1'b0);
      next_edge();
      checks++;
      if (q8 !== e8 || q1 !== e1 || qn1 !== 1'b1) begin
         errors++;
         $display("FAIL width_reload q8=%h q1=%b qn1=%b required q8=%h q1=%b", q8, q1, qn1, e8, e1);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 24; i++) begin
         drive(1'($urandom_range(0, 1)), 32'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
         next_edge();
         checks++;
         if (q32 !== e32 || q8 !== e8 || q1 !== e1) begin
            errors++;
            $display("FAIL back_to_back[%0d] q32=%h q8=%h q1=%b required %h %h %b",
                     i, q32, q8, q1, e32, e8, e1);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load();
      test_hold();
      test_async_reset();
      test_width();
      test_back_to_back();
      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
